mmtranspose_per: RTL
====================

// Module: mmtranspose_per
//
// PURPOSE
// - 4x4 16-bit matrix transpose accelerator on the openMSP430 peripheral bus.
// - Instantiated in toplevel beside gpio/timerA/uart/mmreg; per_dout is OR-ed into the CPU per_dout bus.
// - CPU loads the matrix through a memory-mapped window and writes START.
// - An FSM transposes the matrix in place, one swap per cycle; CPU polls STATUS or takes irq_done.
//
// PARAMETERS
// - BASE_ADDR  15'h0200  byte base address; 64-byte aligned (decode width DEC_WD = 6).
//
// PORTS
// - mclk      in   1   main system clock; the only clock.
// - reset_n   in   1   synchronous, active-low reset, sampled on mclk rising edge. Toplevel drives it with ~puc_rst.
// - per_addr  in   14  peripheral word address.
// - per_din   in   16  peripheral write data.
// - per_en    in   1   peripheral access enable, high active.
// - per_we    in   2   byte write enables: [0] low byte, [1] high byte.
// - per_dout  out  16  read data; 16'h0000 whenever not selected.
// - irq_done  out  1   level interrupt = DONE & IRQ_EN.
//
// BEHAVIOUR
// Address decode
// - sel = per_en & (per_addr[13:5] == BASE_ADDR[14:6]).
// - Word index w = per_addr[4:0].
// - Register map:
//   - w0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (read/write).
//   - w1 STATUS: bit0 BUSY (read-only); bit1 DONE (sticky, write-1-clear); bit2 ERR (sticky, write-1-clear).
//   - w2 CYCLES: read-only count of RUN cycles of the last operation.
//   - w16..w31 M[r][c] at w = 16 + 4*r + c.
//   - Other indices read 0; writes to them are ignored.
//
// Bus reads and writes
// - Reads are combinational: per_dout = sel & ~|per_we ? reg : 0.
// - Writes honour per_we per byte.
// - A byte write to CTRL.START uses low-byte bit0.
//
// Reset
// - reset_n=0 at a clock edge sets: state IDLE, IRQ_EN=0, DONE=0, ERR=0, CYCLES=0, all M=0, irq_done=0.
// - This applies mid-operation as well; the in-progress transpose is abandoned.
//
// FSM: IDLE, RUN
// - IDLE -> RUN on a START write. RUN loads indices (i,j)=(0,1) and clears DONE and CYCLES.
// - Each RUN cycle:
//   - swap M[i][j] and M[j][i] in one register update;
//   - CYCLES += 1;
//   - advance j; when j==3, set i=i+1 and j=i+2.
// - Swap order: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
// - The swap at (2,3) returns the FSM to IDLE and sets DONE=1.
// - Timing: START written in cycle t.
//   - BUSY=1 in cycles t+1..t+6.
//   - In cycle t+7: BUSY=0, DONE=1, CYCLES=6, irq_done=IRQ_EN.
// - The diagonal is never touched.
//
// Boundary conditions
// - START while BUSY: ignored; ERR set.
// - Matrix write while BUSY: ignored (no byte changes); ERR set.
// - Matrix read while BUSY: returns the live, partially transposed contents.
// - Write of 1 to DONE in the same cycle the FSM sets DONE: the set wins.
// - START together with IRQ_EN in one CTRL write: both take effect.
// - DONE write-1-clear drops irq_done in the next cycle.
// - Two back-to-back transposes restore the original matrix.
//
// TESTING
// 1. Reset: drive reset_n=0 mid-RUN -> next cycle BUSY=0, DONE=0, every M reads 0, irq_done=0.
// 2. Load M[r][c]=16'h0100*r+c, write CTRL=1 -> BUSY high for exactly 6 cycles; afterwards M[r][c] reads 16'h0100*c+r, CYCLES=6, DONE=1.
// 3. IRQ: CTRL=3 -> irq_done rises at t+7; write STATUS=2 -> irq_done=0, DONE=0.
// 4. Bus contention: during BUSY write w17=16'hBEEF and CTRL=1 -> ERR=1, matrix result unchanged from test 2, op length still 6.
// 5. Byte writes: per_we=01 with 16'hAA55 to w21 (prior 16'h1234) -> reads 16'h1255; per_we=10 -> 16'hAA34.
// 6. Decode: access at BASE_ADDR+0x40 and unselected cycles -> per_dout=0; second START after DONE returns original matrix.

Source files
------------

// File: rtl/mmtranspose_per_if.sv
// rtl/mmtranspose_per_if.sv - openMSP430 peripheral bus bundle for the transpose block
interface mmtranspose_per_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        irq_done;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout, irq_done
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout, irq_done
    );
endinterface

// File: rtl/mmtranspose_per.sv
// rtl/mmtranspose_per.sv - 4x4 16-bit in-place matrix transpose peripheral
module mmtranspose_per #(
    parameter logic [14:0] BASE_ADDR = 15'h0200
) (
    input  logic               mclk,
    input  logic               reset_n,
    mmtranspose_per_if.slave   bus
);
    localparam int DEC_WD = 6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  i_q, i_d, j_q, j_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] cycles_q, cycles_d;
    logic [15:0] m_q [16];
    logic [15:0] m_d [16];

    logic        sel, wr, busy, start;
    logic [4:0]  w;
    logic [15:0] rdata;

    // Bus decode, register writes, error flags and the swap FSM
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        m_d      = m_q;
        start    = 1'b0;

        sel  = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
        wr   = sel & (|bus.per_we);
        w    = bus.per_addr[4:0];
        busy = (state_q == S_RUN);

        // Write-1-clear is applied before the FSM so a same-cycle set wins
        if (wr) begin
            if (w == 5'd0 && bus.per_we[0]) begin
                irq_en_d = bus.per_din[1];
                start    = bus.per_din[0];
            end else if (w == 5'd1 && bus.per_we[0]) begin
                if (bus.per_din[1]) done_d = 1'b0;
                if (bus.per_din[2]) err_d  = 1'b0;
            end else if (w[4]) begin
                if (busy) begin
                    err_d = 1'b1;
                end else begin
                    if (bus.per_we[0]) m_d[w[3:0]][7:0]  = bus.per_din[7:0];
                    if (bus.per_we[1]) m_d[w[3:0]][15:8] = bus.per_din[15:8];
                end
            end
        end

        if (start && busy) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    i_d      = 2'd0;
                    j_d      = 2'd1;
                    done_d   = 1'b0;
                    cycles_d = 16'd0;
                end
            end
            S_RUN: begin
                // Element (r,c) lives at index {r,c}; both halves of the pair swap at once
                m_d[{i_q, j_q}] = m_q[{j_q, i_q}];
                m_d[{j_q, i_q}] = m_q[{i_q, j_q}];
                cycles_d = cycles_q + 16'd1;
                if (i_q == 2'd2 && j_q == 2'd3) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (j_q == 2'd3) begin
                    i_d = i_q + 2'd1;
                    j_d = i_q + 2'd2;
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Combinational read mux; zero whenever not a selected read
    always_comb begin
        rdata = 16'h0000;
        if (sel && !(|bus.per_we)) begin
            if (w[4]) begin
                rdata = m_q[w[3:0]];
            end else begin
                case (w)
                    5'd0:    rdata = {14'd0, irq_en_q, 1'b0};
                    5'd1:    rdata = {13'd0, err_q, done_q, busy};
                    5'd2:    rdata = cycles_q;
                    default: rdata = 16'h0000;
                endcase
            end
        end
    end

    assign bus.per_dout = rdata;
    assign bus.irq_done = done_q & irq_en_q;

    // State registers with synchronous active-low reset
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            i_q      <= 2'd0;
            j_q      <= 2'd1;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cycles_q <= 16'd0;
            for (int k = 0; k < 16; k++) m_q[k] <= 16'h0000;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
            for (int k = 0; k < 16; k++) m_q[k] <= m_d[k];
        end
    end
endmodule
